intfmux8_tx: RTL and testbench

- Transmit-side serializer for FPGA-to-FPGA integration links.
- Accepts one DATABIT-wide word per frame on a valid/ready handshake.
- Splits the word into DEMUX lanes of LINEBIT bits and sends them MSB lane first, each lane held for MAXTS synclk cycles.
- Generates the sync strobe osyn that marks lane 0 of every frame, so the matching receive-side demux of equal parameters can recover the word.

---
 rtl/intfmux8_tx.sv | 102 ++++++++++
 tb/tb_intfmux8_tx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/intfmux8_tx.sv
// Transmit serializer: one DATABIT word per frame, sent MSB lane first, each lane held MAXTS cycles.
// Optional INTFMUX8_IDLEZERO_EN: underrun frames carry zeros instead of repeating the last word.
module intfmux8_tx #(
  parameter int LINEBIT = 1,
  parameter int DEMUX   = 4,
  parameter int BITTS   = 3,
  parameter int MAXTS   = 6,
  parameter int DATABIT = DEMUX*LINEBIT
) (
  input  logic               synclk,
  input  logic               rst,
  input  logic [DATABIT-1:0] idat,
  input  logic               ivalid,
  output logic               iready,
  output logic [LINEBIT-1:0] odat,
  output logic               osyn,
  output logic               ounder
);
  localparam int PW = (DEMUX > 1) ? $clog2(DEMUX) : 1;

  logic [BITTS-1:0]   cntts_q, cntts_d;
  logic [PW-1:0]      cntph_q, cntph_d;
  logic [DATABIT-1:0] shreg_q, shreg_d;
  logic [DATABIT-1:0] hreg_q, hreg_d;
  logic               hvalid_q, hvalid_d;
  logic [LINEBIT-1:0] odat_q, odat_d;
  logic               osyn_q, osyn_d;
  logic               ounder_q, ounder_d;
  logic               ts_wrap, endframe, xfer;
  logic [LINEBIT-1:0] lane;

  always_comb begin
    ts_wrap  = (cntts_q == BITTS'(MAXTS-1));
    endframe = ts_wrap && (cntph_q == PW'(DEMUX-1));
    iready   = ~hvalid_q | endframe;
    xfer     = ivalid & iready;

    cntts_d = ts_wrap ? '0 : cntts_q + BITTS'(1);
    cntph_d = cntph_q;
    if (ts_wrap)
      cntph_d = (cntph_q == PW'(DEMUX-1)) ? '0 : cntph_q + PW'(1);

    lane = '0;
    for (int i = 0; i < DEMUX; i++)
      if (cntph_q == PW'(i)) lane = shreg_q[DATABIT-1-i*LINEBIT -: LINEBIT];
    odat_d = lane;

    // A single-lane frame has no phase to key on, so the strobe dips on the last slot instead.
    if (DEMUX >= 2) osyn_d = (cntph_q == '0);
    else            osyn_d = ~ts_wrap;

    shreg_d  = shreg_q;
    hreg_d   = hreg_q;
    hvalid_d = hvalid_q;
    ounder_d = 1'b0;
    if (endframe) begin
      if (hvalid_q) begin
        shreg_d = hreg_q;
        if (xfer) hreg_d   = idat;
        else      hvalid_d = 1'b0;
      end else if (xfer) begin
        shreg_d = idat;
      end else begin
        ounder_d = 1'b1;
`ifdef INTFMUX8_IDLEZERO_EN
        shreg_d = '0;
`else
        shreg_d = shreg_q;
`endif
      end
    end else if (xfer) begin
      hreg_d   = idat;
      hvalid_d = 1'b1;
    end
  end

  always_ff @(posedge synclk or posedge rst) begin
    if (rst) begin
      cntts_q  <= '0;
      cntph_q  <= '0;
      shreg_q  <= '0;
      hreg_q   <= '0;
      hvalid_q <= 1'b0;
      odat_q   <= '0;
      osyn_q   <= 1'b0;
      ounder_q <= 1'b0;
    end else begin
      cntts_q  <= cntts_d;
      cntph_q  <= cntph_d;
      shreg_q  <= shreg_d;
      hreg_q   <= hreg_d;
      hvalid_q <= hvalid_d;
      odat_q   <= odat_d;
      osyn_q   <= osyn_d;
      ounder_q <= ounder_d;
    end
  end

  assign odat   = odat_q;
  assign osyn   = osyn_q;
  assign ounder = ounder_q;
endmodule

// File: tb/tb_intfmux8_tx.sv
// Directed bench for intfmux8_tx: default-parameter frame checks plus a 2x3x8 loopback through a behavioural receiver.
module tb_intfmux8_tx;
  logic synclk = 1'b0;
  logic rst = 1'b1, rst2 = 1'b1;
  logic [3:0] idat = '0;
  logic ivalid = 1'b0;
  logic iready, osyn, ounder;
  logic [0:0] odat;
  logic [5:0] idat2 = '0;
  logic ivalid2 = 1'b0;
  logic iready2, osyn2, ounder2;
  logic [1:0] odat2;

  int n_run = 0, n_fail = 0, n_rx = 0;
  int k;
  logic [3:0] feed_q[$];
  logic [5:0] sent_q[$];

`ifdef INTFMUX8_IDLEZERO_EN
  localparam bit IDLEZ = 1'b1;
`else
  localparam bit IDLEZ = 1'b0;
`endif

  intfmux8_tx #(.LINEBIT(1), .DEMUX(4), .BITTS(3), .MAXTS(6)) dut (
    .synclk(synclk), .rst(rst), .idat(idat), .ivalid(ivalid), .iready(iready),
    .odat(odat), .osyn(osyn), .ounder(ounder));

  intfmux8_tx #(.LINEBIT(2), .DEMUX(3), .BITTS(3), .MAXTS(8)) dut2 (
    .synclk(synclk), .rst(rst2), .idat(idat2), .ivalid(ivalid2), .iready(iready2),
    .odat(odat2), .osyn(osyn2), .ounder(ounder2));

  always #5 synclk = ~synclk;

  // posedges since release; the next posedge handles frame position k%24
  always @(posedge synclk or posedge rst)
    if (rst) k <= 0;
    else     k <= k + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_pos(input int p);
    while (k % 24 != p) @(negedge synclk);
  endtask

  // Entered at a negedge with k%24==0: checks the underrun flag of the frame boundary just crossed,
  // then every cycle of the frame now on the line.
  task automatic check_frame(input logic [3:0] w, input logic under);
    chk("ounder_edge", ounder, under);
    for (int j = 0; j < 24; j++) begin
      @(negedge synclk);
      chk("odat", odat, w[3 - j/6]);
      chk("osyn", osyn, j < 6);
      if (j < 23) chk("ounder_mid", ounder, 1'b0);
    end
  endtask

  // Feeder for the default instance: drives the head of feed_q, pops it once iready is seen.
  initial forever begin
    @(posedge synclk); #2;
    if (feed_q.size() > 0) begin
      ivalid = 1'b1;
      idat   = feed_q[0];
      if (iready) feed_q.delete(0);
    end else begin
      ivalid = 1'b0;
      idat   = 4'($urandom);
    end
  end

  // Loopback feeder: always valid, fresh random word after each accepted one.
  initial forever begin
    @(posedge synclk); #2;
    if (rst2) ivalid2 = 1'b0;
    else begin
      ivalid2 = 1'b1;
      if (iready2) begin
        idat2 = 6'($urandom);
        sent_q.push_back(idat2);
      end
    end
  end

  // Receiver: finds lane 0 from the osyn rising edge, samples mid-slot.
  initial begin
    logic rx_prev, rx_act, rx_skip;
    int rx_c, idx;
    logic [5:0] rx_w;
    rx_prev = 0; rx_act = 0; rx_skip = 1; rx_c = 0; rx_w = '0;
    forever begin
      @(negedge synclk);
      if (rst2) begin
        rx_prev = 0; rx_act = 0; rx_skip = 1;
      end else begin
        if (osyn2 && !rx_prev) begin rx_act = 1; rx_c = 0; end
        else if (rx_act) rx_c++;
        rx_prev = osyn2;
        if (rx_act && rx_c % 8 == 4 && rx_c < 24) begin
          idx = rx_c / 8;
          rx_w[5 - 2*idx -: 2] = odat2;
          if (idx == 2) begin
            if (rx_skip) rx_skip = 0;
            else if (sent_q.size() == 0) chk("loop_q", 0, 1);
            else begin
              chk("loop", rx_w, sent_q[0]);
              sent_q.delete(0);
              n_rx++;
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge synclk);
    chk("rst_iready", iready, 1'b1);
    chk("rst_odat", odat, 1'b0);
    chk("rst_osyn", osyn, 1'b0);
    chk("rst_ounder", ounder, 1'b0);
    rst = 1'b0;

    // idle: zeros, periodic strobe, underrun every frame after the first
    check_frame(4'h0, 1'b0);
    check_frame(4'h0, 1'b1);

    // single word into hreg one cycle before endframe
    wait_pos(21);
    feed_q.push_back(4'b1011);
    wait_pos(0);
    check_frame(4'b1011, 1'b0);
    check_frame(IDLEZ ? 4'h0 : 4'b1011, 1'b1);

    // streaming with hreg drain + refill at each endframe
    feed_q.push_back(4'hA); feed_q.push_back(4'h5);
    feed_q.push_back(4'hC); feed_q.push_back(4'h3);
    wait_pos(1);  chk("iready_empty", iready, 1'b1);
    wait_pos(2);  chk("iready_full", iready, 1'b0);
    wait_pos(23); chk("iready_endframe", iready, 1'b1);
    wait_pos(0);
    check_frame(4'hA, 1'b0);
    check_frame(4'h5, 1'b0);
    check_frame(4'hC, 1'b0);
    check_frame(4'h3, 1'b0);
    check_frame(IDLEZ ? 4'h0 : 4'h3, 1'b1);

    // bypass straight into shreg on the endframe cycle
    wait_pos(22);
    feed_q.push_back(4'h6);
    wait_pos(0);
    check_frame(4'h6, 1'b0);

    // underrun after 4'h9
    feed_q.push_back(4'h9);
    check_frame(IDLEZ ? 4'h0 : 4'h6, 1'b1);
    check_frame(4'h9, 1'b0);
    check_frame(IDLEZ ? 4'h0 : 4'h9, 1'b1);

    // loopback through the second instance
    chk("rst2_iready", iready2, 1'b1);
    chk("rst2_osyn", osyn2, 1'b0);
    rst2 = 1'b0;
    chk("rel_osyn_pre", osyn2, 1'b0);
    @(negedge synclk);
    chk("rel_osyn", osyn2, 1'b1);
    repeat (253) @(negedge synclk);
    rst2 = 1'b1;
    sent_q.delete();
    repeat (3) @(negedge synclk);
    chk("midrst_osyn", osyn2, 1'b0);
    chk("midrst_odat", odat2, 2'b00);
    rst2 = 1'b0;
    chk("rel2_osyn_pre", osyn2, 1'b0);
    @(negedge synclk);
    chk("rel2_osyn", osyn2, 1'b1);
    repeat (200) @(negedge synclk);
    chk("loop_words", n_rx >= 12, 1'b1);
    chk("loop_under", ounder2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
